multi_operand_accumulator: RTL



---
 rtl/rca_pkg.sv | 18 +
 rtl/rca_acc_stage.sv | 23 ++
 rtl/multi_operand_accumulator.sv | 86 ++++++++
 3 files changed

// File: rtl/rca_pkg.sv
// Shared types and width helpers for the ripple-carry accumulator and its tree-adder sibling.
package rca_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

  // Wide enough that K operands of all-ones never overflow.
  function automatic int sum_width(input int n, input int k);
    return n + $clog2(k);
  endfunction

  function automatic int count_width(input int k);
    return $clog2(k + 1);
  endfunction

endpackage

// File: rtl/rca_acc_stage.sv
// Combinational W-bit ripple-carry adder built from full-adder cells.
module rca_acc_stage #(
  parameter int W = 6
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] s_o,
  output logic         cout_o
);

  logic [W:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = c[W];

endmodule

// File: rtl/multi_operand_accumulator.sv
// Sums groups of up to K streamed operands through a registered ripple-carry stage
// and hands each group sum downstream over valid/ready.
module multi_operand_accumulator
  import rca_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int K  = 4,
  localparam int SW = sum_width(N, K),
  localparam int CW = count_width(K)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SW-1:0] out_sum,
  output logic [CW-1:0] out_count
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // the producer holds data stable while valid && !ready.

  state_e        state_q;
  logic [SW-1:0] acc_q;
  logic [SW-1:0] sum_d;
  logic [SW-1:0] opnd;
  logic [SW-1:0] sum_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] count_q;
  logic          close_grp;
  logic          unused_cout;

  assign opnd      = SW'(in_data);
  assign cnt_d     = cnt_q + CW'(1);
  assign close_grp = in_last || (cnt_d == CW'(K));

  rca_acc_stage #(.W(SW)) u_stage (
    .a_i    (acc_q),
    .b_i    (opnd),
    .cin_i  (1'b0),
    .s_o    (sum_d),
    .cout_o (unused_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid) begin
            if (close_grp) begin
              sum_q   <= sum_d;
              count_q <= cnt_d;
              acc_q   <= '0;
              cnt_q   <= '0;
              state_q <= DONE;
            end else begin
              acc_q <= sum_d;
              cnt_q <= cnt_d;
            end
          end
        end
        DONE: begin
          // Result stays frozen until taken; no bypass into a new group.
          if (out_ready) state_q <= ACCUM;
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign out_sum   = sum_q;
  assign out_count = count_q;

endmodule
